// File: rtl/s2_pool_ctrl.sv
// S2 pooling controller: feeds C1 pixel groups to the pooling bank and writes
// pooled results into the S2 buffer. Optional macro S2_PERF_CNT_EN adds frame_cycles.
module s2_pool_ctrl #(
  parameter int FM_W     = 28,
  parameter int OUT_BITS = 16,
  parameter int IN_CH    = 6,
  parameter int ADDR_W   = 8,
  parameter int TMO      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      src_valid,
  output logic                      src_ready,
  input  logic [IN_CH*OUT_BITS-1:0] src_bus,
  output logic                      pool_valid,
  output logic [IN_CH*OUT_BITS-1:0] pool_bus,
  output logic                      bank_clr_n,
  input  logic                      pool_out_valid,
  input  logic [IN_CH*OUT_BITS-1:0] pool_out_bus,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [IN_CH*OUT_BITS-1:0] wr_data,
  output logic                      busy,
  output logic                      done,
`ifdef S2_PERF_CNT_EN
  output logic [31:0]               frame_cycles,
`endif
  output logic                      err
);

  localparam int BUS_W     = IN_CH * OUT_BITS;
  localparam int IN_TOTAL  = FM_W * FM_W;
  localparam int OUT_TOTAL = (FM_W / 2) * (FM_W / 2);
  localparam int IN_CW     = $clog2(IN_TOTAL + 1);
  localparam int OUT_CW    = $clog2(OUT_TOTAL + 1);
  localparam int TMO_CW    = $clog2(TMO + 1);

  localparam logic [IN_CW-1:0]  IN_FULL  = IN_CW'(IN_TOTAL);
  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_TOTAL - 1);
  localparam logic [OUT_CW-1:0] OUT_FULL = OUT_CW'(OUT_TOTAL);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_TOTAL - 1);
  localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IN_CW-1:0]  r_in_cnt;
  logic [OUT_CW-1:0] r_out_cnt;
  logic [TMO_CW-1:0] r_tmo_cnt;
  logic              r_err;
  logic              r_pool_valid;
  logic [BUS_W-1:0]  r_pool_bus;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [BUS_W-1:0]  r_wr_data;
  logic              r_bank_clr_n;

  logic w_beat;
  logic w_in_full;
  logic w_in_last;
  logic w_out_full;
  logic w_out_acc;
  logic w_out_last;
  logic w_tmo_hit;
  logic w_err_evt;

  // A result is only accepted while a frame is collecting and the buffer is not yet full.
  assign w_beat     = src_ready & src_valid;
  assign w_in_full  = (r_in_cnt == IN_FULL);
  assign w_in_last  = w_beat & (r_in_cnt == IN_LAST);
  assign w_out_full = (r_out_cnt == OUT_FULL);
  assign w_out_acc  = pool_out_valid & ((r_state == S_FEED) | (r_state == S_DRAIN)) & ~w_out_full;
  assign w_out_last = w_out_acc & (r_out_cnt == OUT_LAST);
  assign w_tmo_hit  = (r_state == S_DRAIN) & ~pool_out_valid & (r_tmo_cnt == TMO_LAST);
  assign w_err_evt  = (pool_out_valid & ~w_out_acc) | w_tmo_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_CLR;
        S_CLR:   w_next = S_FEED;
        S_FEED: begin
          if (w_out_last) begin
            w_next = S_DONE;
          end else if (w_in_last) begin
            w_next = S_DRAIN;
          end
        end
        S_DRAIN: if (w_out_last || w_tmo_hit) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    src_ready = (r_state == S_FEED);
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_CLR) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_beat && !w_in_full) r_in_cnt <= r_in_cnt + 1'b1;
        if (w_out_acc) r_out_cnt <= r_out_cnt + 1'b1;
      end
      if (r_state == S_DRAIN && !pool_out_valid && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end else if (r_state == S_CLR) begin
        r_err <= 1'b0;
      end
    end
  end

  // Write path ignores abort so a result accepted on the abort cycle still lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pool_valid <= 1'b0;
      r_pool_bus   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_bank_clr_n <= 1'b0;
    end else begin
      r_pool_valid <= w_beat;
      if (w_beat) r_pool_bus <= src_bus;
      r_wr_en <= w_out_acc;
      if (w_out_acc) begin
        r_wr_addr <= ADDR_W'(r_out_cnt);
        r_wr_data <= pool_out_bus;
      end
      r_bank_clr_n <= (w_next != S_CLR);
    end
  end

  assign pool_valid = r_pool_valid;
  assign pool_bus   = r_pool_bus;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign bank_clr_n = r_bank_clr_n;
  assign err        = r_err;

`ifdef S2_PERF_CNT_EN
  logic [31:0] r_frame_cycles;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cycles <= '0;
    end else if (r_state == S_CLR) begin
      r_frame_cycles <= 32'd1;
    end else if (r_state != S_IDLE) begin
      r_frame_cycles <= r_frame_cycles + 32'd1;
    end
  end

  assign frame_cycles = r_frame_cycles;
`else
  // Frame cycle counter not built.
`endif

endmodule

// File: tb/tb_s2_pool_ctrl.sv
// Bench for s2_pool_ctrl: a behavioural pooling bank drives results back, and a
// 2x2-max reference computed from the frame's pixel table predicts every write.
module tb_s2_pool_ctrl;

  localparam int FM_W     = 4;
  localparam int OUT_BITS = 16;
  localparam int IN_CH    = 6;
  localparam int ADDR_W   = 4;
  localparam int TMO      = 8;
  localparam int BUS_W    = IN_CH * OUT_BITS;
  localparam int NPIX     = FM_W * FM_W;
  localparam int NOUT     = (FM_W / 2) * (FM_W / 2);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              src_valid = 1'b0;
  logic              src_ready;
  logic [BUS_W-1:0]  src_bus = '0;
  logic              pool_valid;
  logic [BUS_W-1:0]  pool_bus;
  logic              bank_clr_n;
  logic              pool_out_valid;
  logic [BUS_W-1:0]  pool_out_bus;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BUS_W-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;

  s2_pool_ctrl #(
    .FM_W(FM_W), .OUT_BITS(OUT_BITS), .IN_CH(IN_CH), .ADDR_W(ADDR_W), .TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .src_bus(src_bus),
    .pool_valid(pool_valid), .pool_bus(pool_bus), .bank_clr_n(bank_clr_n),
    .pool_out_valid(pool_out_valid), .pool_out_bus(pool_out_bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int compareCount = 0;
  int failCount = 0;

  logic [BUS_W-1:0] pixArr [NPIX];

  // Pooling bank: collects raster pixels and emits a block max after each block's last pixel.
  logic [BUS_W-1:0] bankMem [NPIX];
  int               bankIdx = 0;
  logic             bOutValid = 1'b0;
  logic [BUS_W-1:0] bOutBus = '0;
  logic             withholdLast = 1'b0;
  logic             injectPov = 1'b0;

  assign pool_out_valid = bOutValid | injectPov;
  assign pool_out_bus   = bOutBus;

  function automatic logic [BUS_W-1:0] bankMax(input int idx, input logic [BUS_W-1:0] cur);
    logic [BUS_W-1:0] res;
    logic [OUT_BITS-1:0] m;
    logic [OUT_BITS-1:0] a, b, c;
    for (int ch = 0; ch < IN_CH; ch++) begin
      m = cur[ch*OUT_BITS +: OUT_BITS];
      a = bankMem[idx-1][ch*OUT_BITS +: OUT_BITS];
      b = bankMem[idx-FM_W][ch*OUT_BITS +: OUT_BITS];
      c = bankMem[idx-FM_W-1][ch*OUT_BITS +: OUT_BITS];
      if (a > m) m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      res[ch*OUT_BITS +: OUT_BITS] = m;
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (!bank_clr_n) begin
      bankIdx   <= 0;
      bOutValid <= 1'b0;
    end else begin
      bOutValid <= 1'b0;
      if (pool_valid && bankIdx < NPIX) begin
        bankMem[bankIdx] <= pool_bus;
        bankIdx <= bankIdx + 1;
        if (((bankIdx / FM_W) % 2 == 1) && ((bankIdx % FM_W) % 2 == 1)) begin
          bOutBus   <= bankMax(bankIdx, pool_bus);
          bOutValid <= !(withholdLast && bankIdx == NPIX - 1);
        end
      end
    end
  end

  // Passive monitor, sampling on the falling edge.
  int               wrAddrQ [$];
  logic [BUS_W-1:0] wrDataQ [$];
  int pvCount = 0;
  int doneCount = 0;
  int clrCount = 0;
  int drainCount = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wrAddrQ.push_back(int'(wr_addr));
      wrDataQ.push_back(wr_data);
    end
    if (pool_valid) pvCount <= pvCount + 1;
    if (done) doneCount <= doneCount + 1;
    if (!bank_clr_n) clrCount <= clrCount + 1;
    if (busy && !src_ready && bank_clr_n && !done) drainCount <= drainCount + 1;
  end

  int baseWr, basePv, baseDone, baseClr, baseDrain;

  function automatic logic [BUS_W-1:0] refBlock(input int blk);
    logic [BUS_W-1:0] res;
    logic [OUT_BITS-1:0] m, v;
    int br, bc;
    br = blk / (FM_W / 2);
    bc = blk % (FM_W / 2);
    for (int ch = 0; ch < IN_CH; ch++) begin
      m = '0;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          v = pixArr[(2*br + dr)*FM_W + 2*bc + dc][ch*OUT_BITS +: OUT_BITS];
          if (v > m) m = v;
        end
      end
      res[ch*OUT_BITS +: OUT_BITS] = m;
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [BUS_W-1:0] observed,
                             input logic [BUS_W-1:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic fillPix(input int randomMode);
    for (int k = 0; k < NPIX; k++) begin
      if (randomMode != 0) begin
        pixArr[k] = {$urandom(), $urandom(), $urandom()};
      end else begin
        for (int ch = 0; ch < IN_CH; ch++) pixArr[k][ch*OUT_BITS +: OUT_BITS] = OUT_BITS'(k);
      end
    end
  endtask

  task automatic takeBase();
    baseWr    = wrAddrQ.size();
    basePv    = pvCount;
    baseDone  = doneCount;
    baseClr   = clrCount;
    baseDrain = drainCount;
  endtask

  task automatic startFrame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gapMode 0: back-to-back, 1: valid toggles 1,0, 2: random gaps.
  task automatic applyStimulus(input int nBeats, input int gapMode);
    int c;
    for (int k = 0; k < nBeats; k++) begin
      src_valid = 1'b1;
      src_bus   = pixArr[k];
      c = 0;
      while (!src_ready && c < 100) begin
        @(negedge clk);
        c++;
      end
      if (c >= 100) checkOutput("src_ready_timeout", BUS_W'(src_ready), BUS_W'(1));
      @(negedge clk);
      src_valid = 1'b0;
      if (gapMode == 1) begin
        @(negedge clk);
      end else if (gapMode == 2) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    src_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int c;
    c = 0;
    while (busy && c < 300) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_idle"}, BUS_W'(busy), BUS_W'(0));
  endtask

  task automatic verifyFrame(input string tag, input int expWr, input int expDrain,
                             input logic expErr);
    int nWr;
    nWr = wrAddrQ.size() - baseWr;
    checkOutput({tag, "_writes"}, BUS_W'(nWr), BUS_W'(expWr));
    for (int i = 0; i < nWr && i < expWr; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), BUS_W'(wrAddrQ[baseWr+i]), BUS_W'(i));
      checkOutput($sformatf("%s_data%0d", tag, i), wrDataQ[baseWr+i], refBlock(i));
    end
    checkOutput({tag, "_pool_valid"}, BUS_W'(pvCount - basePv), BUS_W'(NPIX));
    checkOutput({tag, "_done"}, BUS_W'(doneCount - baseDone), BUS_W'(1));
    checkOutput({tag, "_clr"}, BUS_W'(clrCount - baseClr), BUS_W'(1));
    checkOutput({tag, "_drain"}, BUS_W'(drainCount - baseDrain), BUS_W'(expDrain));
    checkOutput({tag, "_err"}, BUS_W'(err), BUS_W'(expErr));
  endtask

  task automatic runFrame(input string tag, input int gapMode, input int expWr,
                          input int expDrain, input logic expErr);
    takeBase();
    startFrame();
    applyStimulus(NPIX, gapMode);
    waitIdle(tag);
    @(negedge clk);
    verifyFrame(tag, expWr, expDrain, expErr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_src_ready", BUS_W'(src_ready), BUS_W'(0));
    checkOutput("rst_pool_valid", BUS_W'(pool_valid), BUS_W'(0));
    checkOutput("rst_wr_en", BUS_W'(wr_en), BUS_W'(0));
    checkOutput("rst_busy", BUS_W'(busy), BUS_W'(0));
    checkOutput("rst_done", BUS_W'(done), BUS_W'(0));
    checkOutput("rst_err", BUS_W'(err), BUS_W'(0));
    checkOutput("rst_bank_clr_n", BUS_W'(bank_clr_n), BUS_W'(0));
    checkOutput("rst_pool_bus", pool_bus, BUS_W'(0));
    checkOutput("rst_wr_data", wr_data, BUS_W'(0));
    checkOutput("rst_wr_addr", BUS_W'(wr_addr), BUS_W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_clr_n", BUS_W'(bank_clr_n), BUS_W'(1));
    repeat (2) @(negedge clk);

    $display("[TB] raster frame, back-to-back beats");
    fillPix(0);
    runFrame("raster", 0, NOUT, 2, 1'b0);

    $display("[TB] random frame, src_valid toggling");
    fillPix(1);
    runFrame("toggle", 1, NOUT, 2, 1'b0);

    $display("[TB] random frame, random gaps");
    fillPix(1);
    runFrame("gaps", 2, NOUT, 2, 1'b0);

    $display("[TB] result injected while idle");
    takeBase();
    @(negedge clk);
    injectPov = 1'b1;
    @(negedge clk);
    injectPov = 1'b0;
    checkOutput("inject_err", BUS_W'(err), BUS_W'(1));
    checkOutput("inject_wr_en", BUS_W'(wr_en), BUS_W'(0));
    repeat (2) @(negedge clk);
    checkOutput("inject_writes", BUS_W'(wrAddrQ.size() - baseWr), BUS_W'(0));

    $display("[TB] start and abort together in idle");
    takeBase();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", BUS_W'(busy), BUS_W'(0));
    @(negedge clk);
    checkOutput("start_abort_busy2", BUS_W'(busy), BUS_W'(0));
    checkOutput("start_abort_clr", BUS_W'(clrCount - baseClr), BUS_W'(0));

    $display("[TB] abort after seven beats, then a full frame");
    fillPix(1);
    takeBase();
    startFrame();
    applyStimulus(7, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", BUS_W'(busy), BUS_W'(0));
    checkOutput("abort_src_ready", BUS_W'(src_ready), BUS_W'(0));
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", BUS_W'(doneCount - baseDone), BUS_W'(0));
    fillPix(1);
    runFrame("after_abort", 0, NOUT, 2, 1'b0);

    $display("[TB] bank withholds its final result");
    fillPix(1);
    withholdLast = 1'b1;
    runFrame("timeout", 0, NOUT - 1, TMO, 1'b1);
    withholdLast = 1'b0;

    $display("[TB] reset asserted during feed");
    fillPix(1);
    takeBase();
    startFrame();
    applyStimulus(5, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_src_ready", BUS_W'(src_ready), BUS_W'(0));
    checkOutput("midrst_pool_valid", BUS_W'(pool_valid), BUS_W'(0));
    checkOutput("midrst_wr_en", BUS_W'(wr_en), BUS_W'(0));
    checkOutput("midrst_busy", BUS_W'(busy), BUS_W'(0));
    checkOutput("midrst_done", BUS_W'(done), BUS_W'(0));
    checkOutput("midrst_err", BUS_W'(err), BUS_W'(0));
    checkOutput("midrst_bank_clr_n", BUS_W'(bank_clr_n), BUS_W'(0));
    checkOutput("midrst_pool_bus", pool_bus, BUS_W'(0));
    checkOutput("midrst_wr_data", wr_data, BUS_W'(0));
    checkOutput("midrst_wr_addr", BUS_W'(wr_addr), BUS_W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_release_clr_n", BUS_W'(bank_clr_n), BUS_W'(1));
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_done", BUS_W'(doneCount - baseDone), BUS_W'(0));
    checkOutput("midrst_idle", BUS_W'(busy), BUS_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
